// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU round-robin arbiter.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic SEL_ADD = 1'b1;
  localparam logic SEL_SUB = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant: requester ptr wins if valid, else the other one.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = ptr;
    if (!req_valid[ptr]) begin
      grant_idx = ~ptr;
    end
    grant = (req_valid == 2'b00) ? 2'b00 : (2'b01 << grant_idx);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accept, execute for one cycle,
// then hold a registered response until the granted requester consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_sel,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_out,
  output logic               rsp_zero,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_select,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_zero,
  output logic               busy,
  output logic [CNT_W-1:0]   ops_done
);

  state_t             state_reg, state_next;
  logic               ptr_reg;
  logic               gnt_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               sel_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               zero_reg;
  logic [CNT_W-1:0]   done_reg;

  logic [1:0]         grant;
  logic               grant_idx;
  logic               accept;
  logic               fire;

  rr_arb2 u_rr_arb2 (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = (state_reg == IDLE) && (req_valid != 2'b00);
  assign fire   = (state_reg == RESP) && rsp_ready[gnt_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (state_reg != IDLE);
    if (state_reg == IDLE) begin
      req_ready = grant;
    end
    if (state_reg == RESP) begin
      rsp_valid = 2'b01 << gnt_reg;
    end
  end

  // Operands are only ever loaded on acceptance, so the ALU drive cannot follow request inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg  <= 1'b0;
      gnt_reg  <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sel_reg  <= SEL_SUB;
      out_reg  <= '0;
      zero_reg <= 1'b0;
      done_reg <= '0;
    end else begin
      if (accept) begin
        gnt_reg <= grant_idx;
        a_reg   <= req_a[grant_idx*WIDTH +: WIDTH];
        b_reg   <= req_b[grant_idx*WIDTH +: WIDTH];
        sel_reg <= req_sel[grant_idx];
      end
      if (state_reg == EXEC) begin
        out_reg  <= alu_out;
        zero_reg <= alu_zero;
      end
      if (fire) begin
        done_reg <= done_reg + CNT_W'(1);
        ptr_reg  <= ~gnt_reg;
      end
    end
  end

  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_select = sel_reg;
  assign rsp_out    = out_reg;
  assign rsp_zero   = zero_reg;
  assign ops_done   = done_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model and reference ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, req_sel, rsp_valid, rsp_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [W-1:0]  rsp_out, alu_a, alu_b, alu_out;
  logic          rsp_zero, alu_select, alu_zero, busy;
  logic [CW-1:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy), .ops_done(ops_done)
  );

  // Reference ALU sitting outside the arbiter
  assign alu_out  = (alu_select == SEL_ADD) ? W'(alu_a + alu_b) : W'(alu_a - alu_b);
  assign alu_zero = (alu_out == '0);

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which phase the current operation is in, and its data
  int        m_phase;  // 0 waiting for a request, 1 ALU cycle, 2 result offered
  int        m_g, m_ptr, m_a, m_b, m_sel, m_out, m_zero, m_done;

  function automatic int pick(input logic [1:0] v, input int p);
    if (v[p]) return p;
    return 1 - p;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_g = 0; m_ptr = 0; m_a = 0; m_b = 0; m_sel = 0;
      m_out = 0; m_zero = 0; m_done = 0;
    end else begin
      if (m_phase == 0) begin
        if (req_valid != 2'b00) begin
          m_g   = pick(req_valid, m_ptr);
          m_a   = (m_g == 0) ? int'(req_a[3:0]) : int'(req_a[7:4]);
          m_b   = (m_g == 0) ? int'(req_b[3:0]) : int'(req_b[7:4]);
          m_sel = int'(req_sel[m_g]);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_out  = (m_sel == 1) ? (m_a + m_b) % 16 : (m_a - m_b + 16) % 16;
        m_zero = (m_out == 0) ? 1 : 0;
        m_phase = 2;
      end else begin
        if (rsp_ready[m_g]) begin
          m_phase = 0;
          m_done  = (m_done + 1) % 256;
          m_ptr   = 1 - m_g;
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    int exp_rr;
    exp_rr = 0;
    if (!reset && m_phase == 0 && req_valid != 2'b00) exp_rr = 1 << pick(req_valid, m_ptr);
    chk("req_ready", int'(req_ready), exp_rr);
    chk("rsp_valid", int'(rsp_valid), (m_phase == 2) ? (1 << m_g) : 0);
    chk("rsp_out", int'(rsp_out), m_out);
    chk("rsp_zero", int'(rsp_zero), m_zero);
    chk("alu_a", int'(alu_a), m_a);
    chk("alu_b", int'(alu_b), m_b);
    chk("alu_select", int'(alu_select), m_sel);
    chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("ops_done", int'(ops_done), m_done);
    if ((rsp_valid & rsp_ready) != 2'b00)
      $display("rsp: requester=%0d out=%0d zero=%0d ops_done=%0d", rsp_valid[1] ? 1 : 0,
               rsp_out, rsp_zero, ops_done);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int gq[$];
  int oq[$];
  int zq[$];
  int tq[$];

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; req_sel = 2'b00; rsp_ready = 2'b11;
    step(); step();
    @(negedge clk);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset ops_done", int'(ops_done), 0);
    step();
    reset = 1'b0;
    step();

    // Single request: 2 + 3
    req_valid = 2'b01; req_a = 8'h02; req_b = 8'h03; req_sel = 2'b01;
    @(negedge clk); chk("t1 accept", int'(req_ready), 1);
    step(); req_valid = 2'b00; req_a = 8'hff;
    @(negedge clk); chk("t1 alu_a", int'(alu_a), 2); chk("t1 alu_b", int'(alu_b), 3);
    step();
    @(negedge clk);
    chk("t1 rsp_valid", int'(rsp_valid), 1);
    chk("t1 rsp_out", int'(rsp_out), 5);
    chk("t1 rsp_zero", int'(rsp_zero), 0);
    step();
    @(negedge clk); chk("t1 ops_done", int'(ops_done), 1);

    // Zero flag on requester 1: 0 - 0
    step();
    req_valid = 2'b10; req_a = 8'h00; req_b = 8'h00; req_sel = 2'b00;
    @(negedge clk); chk("t2 accept", int'(req_ready), 2);
    step(); req_valid = 2'b00;
    step();
    @(negedge clk);
    chk("t2 rsp_valid", int'(rsp_valid), 2);
    chk("t2 rsp_out", int'(rsp_out), 0);
    chk("t2 rsp_zero", int'(rsp_zero), 1);
    step();

    // Contention: both valid for four operations
    step();
    req_valid = 2'b11; req_a = 8'h72; req_b = 8'h73; req_sel = 2'b01;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) gq.push_back(int'(req_ready));
      if (rsp_valid != 2'b00) begin
        oq.push_back(int'(rsp_out)); zq.push_back(int'(rsp_zero)); tq.push_back(i);
      end
      step();
    end
    req_valid = 2'b00;
    chk("t3 n_grants", gq.size(), 4);
    chk("t3 n_rsp", oq.size(), 4);
    if (gq.size() == 4 && oq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3 grant", gq[i], (i % 2 == 0) ? 1 : 2);
        chk("t3 out", oq[i], (i % 2 == 0) ? 5 : 0);
        chk("t3 zero", zq[i], (i % 2 == 0) ? 0 : 1);
        chk("t3 rsp cycle", tq[i], 3 * i + 2);
      end
    end
    @(negedge clk); chk("t3 ops_done", int'(ops_done), 6);

    // Backpressure with wrap: req0 15+1, req1 2-3 waiting; rsp_ready[1] must be ignored
    step();
    req_valid = 2'b11; req_a = 8'h2f; req_b = 8'h31; req_sel = 2'b01; rsp_ready = 2'b10;
    @(negedge clk); chk("t4 accept0", int'(req_ready), 1);
    step(); req_valid = 2'b10;
    @(negedge clk); chk("t4 exec ready", int'(req_ready), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4 hold valid", int'(rsp_valid), 1);
      chk("t4 hold out", int'(rsp_out), 0);
      chk("t4 hold zero", int'(rsp_zero), 1);
      chk("t4 hold ready", int'(req_ready), 0);
      step();
    end
    rsp_ready = 2'b01;
    @(negedge clk); chk("t4 still valid", int'(rsp_valid), 1);
    step();
    @(negedge clk); chk("t4 accept1", int'(req_ready), 2);
    step(); req_valid = 2'b00; rsp_ready = 2'b11;
    step();
    @(negedge clk);
    chk("t4 rsp1 valid", int'(rsp_valid), 2);
    chk("t4 rsp1 out", int'(rsp_out), 15);
    chk("t4 rsp1 zero", int'(rsp_zero), 0);
    step();
    @(negedge clk); chk("t4 ops_done", int'(ops_done), 8);

    // Reset during EXEC drops the operation
    step();
    req_valid = 2'b01; req_a = 8'h01; req_b = 8'h01; req_sel = 2'b01;
    step(); req_valid = 2'b00;
    @(negedge clk); chk("t5 busy", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("t5 rst busy", int'(busy), 0);
    chk("t5 rst ops_done", int'(ops_done), 0);
    chk("t5 rst alu_a", int'(alu_a), 0);
    chk("t5 rst rsp_out", int'(rsp_out), 0);
    step(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5 no rsp", int'(rsp_valid), 0);
      step();
    end
    chk("t5 ops_done", int'(ops_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
